// File: rtl/divisor_multimodo.sv
// divisor_multimodo: radix-2 restoring divider, one quotient bit per clock,
// signed/unsigned per operation, with abort and divide-by-zero/overflow flags.
module divisor_multimodo #(
   parameter int tamanyo = 32
) (
   input  logic               CLK,
   input  logic               RSTa,
   input  logic               Start,
   input  logic               Signed_Op,
   input  logic               Abort,
   input  logic [tamanyo-1:0] Num,
   input  logic [tamanyo-1:0] Den,
   output logic [tamanyo-1:0] Coc,
   output logic [tamanyo-1:0] Res,
   output logic               Done,
   output logic               Busy,
   output logic               DivZero,
   output logic               Ovf
);
   localparam int CW = $clog2(tamanyo);
   localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, SIGN = 2'd2, ZERO = 2'd3;
   logic [1:0] state_q, state_d;
   logic sn_q, sn_d, sd_q, sd_d, ovfc_q, ovfc_d;
   logic done_q, done_d, dz_q, dz_d, ovf_q, ovf_d;
   logic [CW-1:0] cont_q, cont_d;
   logic [tamanyo-1:0] m_q, m_d, q_q, q_d, accu_q, accu_d, coc_q, coc_d, res_q, res_d;
   logic [tamanyo:0] a, diff;
   logic ns, dsg;
   always_comb begin
      a = {accu_q, q_q[tamanyo-1]};
      // diff[tamanyo] is the borrow: set exactly when the shifted remainder is below the divisor
      diff = a - {1'b0, m_q};
      ns = Signed_Op & Num[tamanyo-1];
      dsg = Signed_Op & Den[tamanyo-1];
      state_d = state_q;
      sn_d = sn_q;
      sd_d = sd_q;
      ovfc_d = ovfc_q;
      cont_d = cont_q;
      m_d = m_q;
      q_d = q_q;
      accu_d = accu_q;
      coc_d = coc_q;
      res_d = res_q;
      dz_d = dz_q;
      ovf_d = ovf_q;
      done_d = 1'b0;
      if (Abort && state_q != IDLE) state_d = IDLE;
      else case (state_q)
         IDLE: if (Start) begin
            sn_d = ns;
            sd_d = dsg;
            m_d = dsg ? -Den : Den;
            q_d = (ns && Den != '0) ? -Num : Num;
            accu_d = '0;
            cont_d = CW'(tamanyo - 1);
            ovfc_d = Signed_Op & (Num == {1'b1, {(tamanyo-1){1'b0}}}) & (&Den);
            state_d = (Den == '0) ? ZERO : CALC;
         end
         CALC: begin
            accu_d = diff[tamanyo] ? a[tamanyo-1:0] : diff[tamanyo-1:0];
            q_d = {q_q[tamanyo-2:0], ~diff[tamanyo]};
            cont_d = cont_q - 1'b1;
            state_d = (cont_q == '0) ? SIGN : CALC;
         end
         SIGN: begin
            coc_d = (sn_q ^ sd_q) ? -q_q : q_q;
            res_d = sn_q ? -accu_q : accu_q;
            ovf_d = ovfc_q;
            dz_d = 1'b0;
            done_d = 1'b1;
            state_d = IDLE;
         end
         default: begin
            coc_d = '1;
            res_d = q_q;
            ovf_d = 1'b0;
            dz_d = 1'b1;
            done_d = 1'b1;
            state_d = IDLE;
         end
      endcase
   end
   always_ff @(posedge CLK) begin
      if (!RSTa) begin
         state_q <= IDLE;
         sn_q <= 1'b0;
         sd_q <= 1'b0;
         ovfc_q <= 1'b0;
         cont_q <= '0;
         m_q <= '0;
         q_q <= '0;
         accu_q <= '0;
         coc_q <= '0;
         res_q <= '0;
         dz_q <= 1'b0;
         ovf_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sn_q <= sn_d;
         sd_q <= sd_d;
         ovfc_q <= ovfc_d;
         cont_q <= cont_d;
         m_q <= m_d;
         q_q <= q_d;
         accu_q <= accu_d;
         coc_q <= coc_d;
         res_q <= res_d;
         dz_q <= dz_d;
         ovf_q <= ovf_d;
         done_q <= done_d;
      end
   end
   assign Coc = coc_q;
   assign Res = res_q;
   assign Done = done_q;
   assign Busy = state_q != IDLE;
   assign DivZero = dz_q;
   assign Ovf = ovf_q;
endmodule

// File: tb/tb_divisor_multimodo.sv
// tb_divisor_multimodo: directed and random stimulus against a transaction-level
// reference built on native truncating division.
module tb_divisor_multimodo;
   localparam int W = 32;
   localparam logic [W-1:0] MIN = 32'h8000_0000;
   logic clk = 1'b0, rsta = 1'b0, start = 1'b0, sgn = 1'b0, abort = 1'b0;
   logic [W-1:0] num = '0, den = '0;
   logic [W-1:0] Coc, Res;
   logic Done, Busy, DivZero, Ovf;
   int n_cmp = 0, n_err = 0;
   divisor_multimodo #(.tamanyo(W)) dut (
      .CLK(clk), .RSTa(rsta), .Start(start), .Signed_Op(sgn), .Abort(abort),
      .Num(num), .Den(den), .Coc(Coc), .Res(Res), .Done(Done), .Busy(Busy),
      .DivZero(DivZero), .Ovf(Ovf)
   );
   always #5 clk = ~clk;
   task automatic ref_div(input logic [W-1:0] n, d, input logic s,
                          output logic [W-1:0] c, r, output logic z, o);
      int sn, sd;
      longint ln, ld, lq, lr;
      sn = n;
      sd = d;
      ln = sn;
      ld = sd;
      z = 1'b0;
      o = 1'b0;
      if (d == '0) begin
         c = '1;
         r = n;
         z = 1'b1;
      end else if (s) begin
         lq = ln / ld;
         lr = ln % ld;
         c = lq[W-1:0];
         r = lr[W-1:0];
         o = (n == MIN) && (d == '1);
      end else begin
         c = n / d;
         r = n % d;
      end
   endtask
   // Model: an accepted op completes a fixed number of edges later unless aborted or reset
   logic m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, m_ovf = 1'b0, p_dz = 1'b0, p_ovf = 1'b0;
   logic [W-1:0] m_coc = '0, m_res = '0, p_coc = '0, p_res = '0;
   logic [W-1:0] p_num = '0, p_den = '0, l_num = '0, l_den = '0;
   int m_cnt = 0;
   always @(posedge clk) begin : model
      logic [W-1:0] c, r;
      logic z, o;
      if (!rsta) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_coc <= '0;
         m_res <= '0;
         m_dz <= 1'b0;
         m_ovf <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_busy && abort) m_busy <= 1'b0;
         else if (m_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_coc <= p_coc;
               m_res <= p_res;
               m_dz <= p_dz;
               m_ovf <= p_ovf;
               l_num <= p_num;
               l_den <= p_den;
            end
         end else if (start) begin
            ref_div(num, den, sgn, c, r, z, o);
            p_coc <= c;
            p_res <= r;
            p_dz <= z;
            p_ovf <= o;
            p_num <= num;
            p_den <= den;
            m_busy <= 1'b1;
            m_cnt <= (den == '0) ? 1 : W + 1;
         end
      end
   end
   logic prev_done = 1'b0;
   logic [W-1:0] ident;
   always @(negedge clk) begin
      n_cmp++;
      if ({Coc, Res, Done, Busy, DivZero, Ovf} !== {m_coc, m_res, m_done, m_busy, m_dz, m_ovf}) begin
         n_err++;
         $display("FAIL cycle t=%0t got coc=%h res=%h done=%b busy=%b dz=%b ovf=%b want coc=%h res=%h done=%b busy=%b dz=%b ovf=%b",
                  $time, Coc, Res, Done, Busy, DivZero, Ovf, m_coc, m_res, m_done, m_busy, m_dz, m_ovf);
      end
      if (Done === 1'b1) begin
         n_cmp++;
         if (prev_done) begin
            n_err++;
            $display("FAIL done_twice t=%0t got two consecutive Done want single pulse", $time);
         end
         if (!DivZero) begin
            ident = Coc * l_den + Res;
            n_cmp++;
            if (ident !== l_num) begin
               n_err++;
               $display("FAIL identity t=%0t got coc*den+res=%h want num=%h", $time, ident, l_num);
            end
         end
      end
      prev_done <= Done;
   end
   task automatic chk(input string nm, input logic [W-1:0] act, exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask
   task automatic launch(input logic [W-1:0] n, d, input logic s);
      @(posedge clk);
      #1 num = n;
      den = d;
      sgn = s;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask
   task automatic wait_done(output int lat);
      bit f;
      f = 0;
      lat = 0;
      for (int i = 0; i < 60 && !f; i++) begin
         @(negedge clk);
         if (Done) f = 1;
         else begin
            @(posedge clk);
            lat++;
         end
      end
      if (!f) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout got no Done want Done within 60 cycles");
      end
   endtask
   task automatic run(input logic [W-1:0] n, d, input logic s, input logic [W-1:0] ec, er, input int el);
      int lat;
      launch(n, d, s);
      wait_done(lat);
      chk("coc", Coc, ec);
      chk("res", Res, er);
      chk("latency", lat, el);
   endtask
   initial begin
      int lat;
      logic [W-1:0] held;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_coc", Coc, '0);
      chk("rst_flags", {Done, Busy, DivZero, Ovf}, '0);
      @(posedge clk);
      #1 rsta = 1'b1;
      run(100, 7, 1, 14, 2, 33);
      run(-32'sd100, 7, 1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);
      run('1, 2, 0, 32'h7FFF_FFFF, 1, 33);
      run('1, 2, 1, 0, '1, 33);
      run(5, 0, 1, '1, 5, 1);
      chk("dz_set", DivZero, 1);
      run(100, 7, 1, 14, 2, 33);
      chk("dz_clear", DivZero, 0);
      run(MIN, '1, 1, MIN, 0, 33);
      chk("ovf_set", Ovf, 1);
      run(MIN, 1, 0, MIN, 0, 33);
      chk("ovf_unsigned", Ovf, 0);
      held = Coc;
      launch(1000, 3, 0);
      repeat (9) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", Busy, 0);
      repeat (40) @(posedge clk);
      chk("abort_held", Coc, held);
      run(1000, 3, 0, 333, 1, 33);
      launch(1000, 3, 0);
      repeat (5) @(posedge clk);
      #1 start = 1'b1;
      num = 7;
      den = 1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat);
      chk("busy_start_coc", Coc, 333);
      num = 50;
      den = 6;
      sgn = 0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat);
      chk("done_cycle_coc", Coc, 8);
      chk("done_cycle_lat", lat, 33);
      launch(100, 7, 1);
      repeat (10) @(posedge clk);
      #1 rsta = 1'b0;
      @(posedge clk);
      #1 rsta = 1'b1;
      @(negedge clk);
      chk("midrst_coc", Coc, '0);
      chk("midrst_res", Res, '0);
      chk("midrst_flags", {Done, Busy, DivZero, Ovf}, '0);
      repeat (40) @(posedge clk);
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1 start = ($urandom % 6) == 0;
         abort = ($urandom % 80) == 0;
         rsta = ($urandom % 700) != 0;
         sgn = $urandom;
         case ($urandom % 10)
            0: begin num = $urandom; den = 0; end
            1: begin num = MIN; den = '1; end
            2, 3: begin num = $urandom_range(0, 255); den = $urandom_range(1, 15);
               if ($urandom % 2) num = -num;
               if ($urandom % 2) den = -den;
            end
            default: begin num = $urandom; den = $urandom >> ($urandom % 32); end
         endcase
      end
      #1 start = 1'b0;
      abort = 1'b0;
      rsta = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
